// File: rtl/vga_timing_pipe.sv
// ============================================================================
// Module   : vga_timing_pipe
// Purpose  : Parametrised VGA timing generator with a pixel-clock divider and
//            a sync/blank delay line. The delay line lines sync and blanking up
//            with multi-cycle renderers. Outputs are registered VGA signals,
//            line/frame strobes and a frame counter.
// Option   : VGA_TEST_PATTERN_EN - when defined, test_pattern=1 replaces
//            rgb_in with eight vertical colour bars.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_pipe #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter int   CLK_DIV    = 4,
  parameter int   PIPE_DEPTH = 2,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   COORD_W    = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               test_pattern,
  input  logic [11:0]        rgb_in,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               pixel_tick,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_count,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  // Delayed x travels with the flags so the bars follow the output pixel.
  localparam int SW = 3 + COORD_W;
`else
  localparam int SW = 3;
`endif

  logic [DIV_W-1:0] div;
  logic             adv;
  logic             x_wrap;
  logic             y_wrap;
  logic             act_raw;
  logic             hs_raw;
  logic             vs_raw;
  logic [SW-1:0]    stage_in;
  logic [SW-1:0]    stage_out;
  logic             d_act;
  logic             d_hs;
  logic             d_vs;
  logic [11:0]      colour;

  // adv marks the clock edge on which every pixel-rate register moves.
  assign adv    = enable && (div == DIV_LAST);
  assign x_wrap = (x == X_LAST);
  assign y_wrap = (y == Y_LAST);

  // Pixel-clock divider; parked at zero while disabled so restart is aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (!enable || adv) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Raster counters, strobes and frame counter; strobes flag the new coordinate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      x           <= '0;
      y           <= '0;
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_tick  <= adv;
      line_start  <= adv && x_wrap;
      frame_start <= adv && x_wrap && y_wrap;
      if (adv) begin
        if (x_wrap) begin
          x <= '0;
          if (y_wrap) begin
            y           <= '0;
            frame_count <= frame_count + 16'd1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  assign act_raw = (x < X_ACT) && (y < Y_ACT);
  assign hs_raw  = (x >= HS_START) && (x < HS_END);
  assign vs_raw  = (y >= VS_START) && (y < VS_END);

`ifdef VGA_TEST_PATTERN_EN
  assign stage_in = {x, act_raw, hs_raw, vs_raw};
`else
  assign stage_in = {act_raw, hs_raw, vs_raw};
`endif

  generate
    if (PIPE_DEPTH == 0) begin : g_no_pipe
      assign stage_out = stage_in;
    end else begin : g_pipe
      logic [SW-1:0] pipe [PIPE_DEPTH];

      // Renderer-latency delay line, shifting once per pixel.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
        end else if (!enable) begin
          for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
        end else if (adv) begin
          pipe[0] <= stage_in;
          for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign stage_out = pipe[PIPE_DEPTH-1];
    end
  endgenerate

  assign d_act = stage_out[2];
  assign d_hs  = stage_out[1];
  assign d_vs  = stage_out[0];

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [COORD_W-1:0] d_x;
  logic [2:0]         bar;
  logic [11:0]        bar_rgb;

  assign d_x = stage_out[SW-1:3];

  // Bar index from the delayed x; bars run white, yellow, cyan, green,
  // magenta, red, blue, black so each component is an inverted index bit.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (d_x >= COORD_W'(i * BAR_W)) bar = 3'(i);
    end
  end

  assign bar_rgb = {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}};
  assign colour  = test_pattern ? bar_rgb : rgb_in;
`else
  logic unused_test_pattern;
  assign unused_test_pattern = test_pattern;
  assign colour              = rgb_in;
`endif

  // Registered VGA outputs; forced to blank with inactive syncs while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      video_on                <= 1'b0;
      hsync                   <= ~SYNC_POL;
      vsync                   <= ~SYNC_POL;
      {vga_r, vga_g, vga_b}   <= 12'h000;
    end else if (!enable) begin
      video_on                <= 1'b0;
      hsync                   <= ~SYNC_POL;
      vsync                   <= ~SYNC_POL;
      {vga_r, vga_g, vga_b}   <= 12'h000;
    end else if (adv) begin
      video_on                <= d_act;
      hsync                   <= d_hs ? SYNC_POL : ~SYNC_POL;
      vsync                   <= d_vs ? SYNC_POL : ~SYNC_POL;
      {vga_r, vga_g, vga_b}   <= d_act ? colour : 12'h000;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_pipe.sv
// ============================================================================
// Module   : tb_vga_timing_pipe
// Purpose  : Directed self-checking bench for vga_timing_pipe using a reduced
//            24x12 raster (16x8 visible), CLK_DIV=4, PIPE_DEPTH=2.
//            Expectations honour VGA_TEST_PATTERN_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_pipe;

  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOTAL = 24, V_TOTAL = 12;
  localparam int CLK_DIV = 4, PIPE_DEPTH = 2, COORD_W = 5;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic               test_pattern = 1'b0;
  logic [11:0]        rgb_in = 12'h000;
  logic [COORD_W-1:0] x, y;
  logic               pixel_tick, line_start, frame_start;
  logic [15:0]        frame_count;
  logic               hsync, vsync, video_on;
  logic [3:0]         vga_r, vga_g, vga_b;

  vga_timing_pipe #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .PIPE_DEPTH(PIPE_DEPTH), .SYNC_POL(1'b0), .COORD_W(COORD_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .test_pattern(test_pattern),
    .rgb_in(rgb_in), .x(x), .y(y), .pixel_tick(pixel_tick),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail = 0;
  int n_fs = 0;
  int mx, my, fcnt;
  int hx [4];
  int hy [4];
  bit hv [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] render(input int cx);
    logic [3:0] n;
    n = 4'(cx);
    return {n, n, n};
  endfunction

  function automatic logic [11:0] bar_colour(input int idx);
    case (idx)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] exp_colour(input int cx);
`ifdef VGA_TEST_PATTERN_EN
    if (test_pattern) return bar_colour(cx / (H_ACTIVE / 8));
`endif
    return render(cx);
  endfunction

  // Model restarts at (0,0) with an all-blank delay line.
  task automatic restart_model();
    mx = 0;
    my = 0;
    for (int i = 0; i < 4; i++) begin
      hx[i] = 0; hy[i] = 0; hv[i] = 1'b0;
    end
    hv[0] = 1'b1;
    rgb_in = 12'h000;
  endtask

  task automatic check_reset_state();
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_pixel_tick", pixel_tick, 0);
    check("rst_line_start", line_start, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_video_on", video_on, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
  endtask

  // Waits for the next pixel tick, advances the model and checks everything.
  task automatic step_tick();
    int  n = 0;
    bit  le, fe, act, hs, vs;
    do begin
      @(negedge clk);
      n++;
    end while (!pixel_tick && n < 4 * CLK_DIV);
    check("tick_period", n, CLK_DIV);

    le = (mx == H_TOTAL - 1);
    fe = le && (my == V_TOTAL - 1);
    if (le) begin
      mx = 0;
      if (fe) begin
        my = 0;
        fcnt = (fcnt + 1) % 65536;
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
    for (int i = 3; i > 0; i--) begin
      hx[i] = hx[i-1]; hy[i] = hy[i-1]; hv[i] = hv[i-1];
    end
    hx[0] = mx; hy[0] = my; hv[0] = 1'b1;

    check("x", x, mx);
    check("y", y, my);
    check("line_start", line_start, le);
    check("frame_start", frame_start, fe);
    check("frame_count", frame_count, fcnt);
    if (frame_start) n_fs++;

    act = hv[3] && hx[3] < H_ACTIVE && hy[3] < V_ACTIVE;
    hs  = hv[3] && hx[3] >= 18 && hx[3] < 21;
    vs  = hv[3] && hy[3] >= 9 && hy[3] < 11;
    check("video_on", video_on, act);
    check("hsync", hsync, !hs);
    check("vsync", vsync, !vs);
    check("rgb", {vga_r, vga_g, vga_b}, act ? exp_colour(hx[3]) : 12'h000);

    rgb_in = hv[2] ? render(hx[2]) : 12'h000;
  endtask

  initial begin
    int fc_hold;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_state();

    // Three full frames from reset
    reset_n = 1'b1;
    enable  = 1'b1;
    fcnt    = 0;
    restart_model();
    for (int k = 0; k < 3 * H_TOTAL * V_TOTAL; k++) step_tick();
    check("frames_done", frame_count, 16'd3);
    check("frame_start_pulses", n_fs, 3);

    // Enable low mid-line for 1000 clks
    for (int k = 0; k < 400 && !(mx == 7 && my == 1); k++) step_tick();
    enable  = 1'b0;
    fc_hold = fcnt;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      check("disabled",
            {pixel_tick, line_start, frame_start, video_on, hsync, vsync,
             vga_r, vga_g, vga_b, x, y, frame_count},
            {3'b000, 1'b0, 1'b1, 1'b1, 12'h000, 5'd0, 5'd0, 16'(fc_hold)});
    end
    enable = 1'b1;
    restart_model();
    for (int k = 0; k < 60; k++) step_tick();
    check("frame_count_held", frame_count, 16'd3);

    // Asynchronous reset mid-frame
    for (int k = 0; k < 400 && !(mx == 10 && my == 4); k++) step_tick();
    reset_n = 1'b0;
    #1;
    check_reset_state();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("restart_x", x, 0);
    check("restart_y", y, 0);
    fcnt = 0;
    restart_model();

    // Colour bars (or pass-through) on line 2
    test_pattern = 1'b1;
    for (int k = 0; k < 200 && !(mx == 0 && my == 4); k++) begin
      step_tick();
      if (hv[3] && hy[3] == 2) begin
`ifdef VGA_TEST_PATTERN_EN
        if (hx[3] == 0)  check("bar_x0",  {vga_r, vga_g, vga_b}, 12'hFFF);
        if (hx[3] == 2)  check("bar_x2",  {vga_r, vga_g, vga_b}, 12'hFF0);
        if (hx[3] == 14) check("bar_x14", {vga_r, vga_g, vga_b}, 12'h000);
`else
        if (hx[3] == 0)  check("bar_x0",  {vga_r, vga_g, vga_b}, 12'h000);
        if (hx[3] == 2)  check("bar_x2",  {vga_r, vga_g, vga_b}, 12'h222);
        if (hx[3] == 14) check("bar_x14", {vga_r, vga_g, vga_b}, 12'hEEE);
`endif
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_pipe.md
# vga_timing_pipe

Parametrised VGA timing generator and output pipeline, next-generation replacement for the fixed 640x480 controller plus combinational RGB mux in the display top. Generates pixel coordinates from a configurable pixel-clock divider and configurable horizontal/vertical timing. Delays sync and blanking through a configurable pipeline so they align with multi-cycle renderers such as the registered font ROM path. Drives registered VGA outputs, plus line/frame strobes and a frame counter for animation logic.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch / sync widths in lines
- `CLK_DIV`, 4, system clocks per pixel (≥1)
- `PIPE_DEPTH`, 2, renderer latency in pixel ticks (0..8)
- `SYNC_POL`, 0, active level of hsync/vsync
- `COORD_W`, 10, width of x/y (must hold H_TOTAL-1, V_TOTAL-1)
- `clk` in 1: system clock, 100 MHz
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: synchronous run enable
- `test_pattern` in 1: select colour bars (only with macro)
- `rgb_in` in 12: {r,g,b} 4 bits each, renderer colour for the coordinate issued PIPE_DEPTH ticks earlier
- `x`, `y` out COORD_W: current raw (undelayed) coordinate
- `pixel_tick` out 1: one-clk strobe, counters advance on it
- `line_start` / `frame_start` out 1: one-clk strobes
- `frame_count` out 16: completed frames
- `hsync`, `vsync`, `video_on` out 1: pipelined, registered
- `vga_r`, `vga_g`, `vga_b` out 4: registered colour

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise (800x525 default).
- Divider counts 0..CLK_DIV-1; `pixel_tick` high for one clk when the divider reaches CLK_DIV-1. With CLK_DIV=1, the tick is high every clk.
- On each tick, x increments. At x=H_TOTAL-1, x wraps to 0 and y increments. At y=V_TOTAL-1 with x wrap, y wraps to 0 and `frame_count` increments, modulo 2^16.
- `line_start` pulses on the tick where x becomes 0. `frame_start` pulses on the tick where (x,y) becomes (0,0); `line_start` pulses on that same tick.
- Raw decode per coordinate:
  - active = x<H_ACTIVE && y<V_ACTIVE
  - hs = H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC
  - vs uses the same form on y
- Delay line of PIPE_DEPTH stages carries {active, hs, vs} and advances only on `pixel_tick`.
- Output registers load on `pixel_tick`:
  - `video_on` = delayed active
  - `hsync` = delayed hs ? SYNC_POL : ~SYNC_POL; `vsync` likewise
  - RGB = delayed active ? `rgb_in` : 0
- `enable` low:
  - divider, x, y and delay line held at 0
  - outputs forced to blank (RGB 0, video_on 0, syncs inactive)
  - no strobes
  - `frame_count` holds its value
- `enable` rising: first tick occurs CLK_DIV clks later, with the coordinate sequence starting at (0,0).

## Timing
- Reset values (async assert, immediate):
  - x=y=0, divider 0, delay line 0, frame_count 0
  - pixel_tick/line_start/frame_start 0
  - video_on 0, RGB 0, hsync=vsync=~SYNC_POL
- Release is synchronous to clk; first tick CLK_DIV clks after the first clk edge with reset_n high and enable high.
- Coordinate (x,y) presented after tick n → its sync/video_on/RGB appear on outputs after tick n+PIPE_DEPTH+1. `rgb_in` is sampled at tick n+PIPE_DEPTH+1.
- Reset asserted mid-frame: all state is cleared, and the frame restarts at (0,0) with no partial strobes.

## Configuration
- `VGA_TEST_PATTERN_EN` defined: when `test_pattern`=1, `rgb_in` is replaced by 8 vertical bars selected by the delayed x, each H_ACTIVE/8 wide. Bar order: white, yellow, cyan, green, magenta, red, blue, black, each component 4'hF or 0. Blanking still applies.
- Undefined: the `test_pattern` port exists but is ignored, and no bar logic is synthesised.

## Test plan
- Reset then enable, defaults: `pixel_tick` period 4 clks; hsync low for 96 ticks starting at x=656; vsync low for 2 lines starting at y=490; 420000 ticks per frame.
- Run 3 frames: `frame_count`=3; `frame_start` pulses exactly 3 times, each coincident with `line_start` and (x,y)=(0,0).
- PIPE_DEPTH=2, `rgb_in`=x[3:0] replicated per component: `vga_r` at the output tick for coordinate x equals x[3:0]; `vga_r`=0 and video_on=0 for x≥640.
- Deassert `reset_n` at x=300, y=200: all outputs take reset values within the same cycle; after release, the first coordinate is (0,0).
- `enable` low for 1000 clks mid-line: no strobes and outputs blank; `frame_count` held; on re-enable, the sequence resumes from (0,0).
- With `VGA_TEST_PATTERN_EN` and `test_pattern`=1, at y=100: x=0→RGB FFF, x=80→FF0, x=560→000. Without the macro, the same stimulus yields `rgb_in`.
